// File: rtl/mini_alu_pkg.sv
// mini_alu shared definitions: opcodes, field widths, instruction word.
// Optional SMUL datapath is enabled with the MINI_ALU_SMUL_EN macro.
package mini_alu_pkg;

    localparam int OP_W    = 4;
    localparam int FIELD_W = 8;
    localparam int PC_W    = 8;
    localparam int IMM_W   = 2 * FIELD_W;
    localparam int INSTR_W = OP_W + 3 * FIELD_W;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'd0,
        OP_LED  = 4'd1,
        OP_BLE  = 4'd2,
        OP_STO  = 4'd3,
        OP_ADD  = 4'd4,
        OP_JMP  = 4'd5,
        OP_SUB  = 4'd6,
        OP_SMUL = 4'd7
    } op_e;

    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [FIELD_W-1:0] dest;
        logic [FIELD_W-1:0] src1;
        logic [FIELD_W-1:0] src0;
    } instr_t;

    function automatic instr_t mk_instr(
        input logic [OP_W-1:0]    op,
        input logic [FIELD_W-1:0] dest,
        input logic [FIELD_W-1:0] src1,
        input logic [FIELD_W-1:0] src0
    );
        instr_t i;
        i.op   = op;
        i.dest = dest;
        i.src1 = src1;
        i.src0 = src0;
        return i;
    endfunction

    function automatic instr_t mk_imm(
        input logic [OP_W-1:0]    op,
        input logic [FIELD_W-1:0] dest,
        input logic [IMM_W-1:0]   imm
    );
        return mk_instr(op, dest, imm[15:8], imm[7:0]);
    endfunction

    // 8x8 signed product, low 16 bits of the sign-extended multiply
    function automatic logic [15:0] smul8(
        input logic [7:0] x,
        input logic [7:0] y
    );
        return {{8{x[7]}}, x} * {{8{y[7]}}, y};
    endfunction

endpackage

// File: rtl/mini_alu_if.sv
// mini_alu observation bus: current PC and a register peek port.
// The master selects a register, the slave returns it combinationally.
interface mini_alu_if
    import mini_alu_pkg::*;
#(
    parameter int DATA_W = 16
);
    logic [PC_W-1:0]   pc;
    logic [3:0]        sel;
    logic [DATA_W-1:0] rdata;

    modport master (
        output sel,
        input  pc,
        input  rdata
    );

    modport slave (
        input  sel,
        output pc,
        output rdata
    );
endinterface

// File: rtl/mini_alu_rom.sv
// mini_alu instruction ROM, combinational read from the 8-bit PC.
// PROG 0 is the LED counting demo, PROG 1 an arithmetic/branch exerciser.
module mini_alu_rom
    import mini_alu_pkg::*;
#(
    parameter int ROM_DEPTH = 256,
    parameter int PROG      = 0
) (
    input  logic [PC_W-1:0] addr,
    output instr_t          instr
);

    // program lookup; unused addresses read as NOP
    always_comb begin
        instr = mk_instr(OP_NOP, 8'd0, 8'd0, 8'd0);
        if (int'(addr) < ROM_DEPTH) begin
            if (PROG == 0) begin
                case (addr)
                    8'd1: instr = mk_imm(OP_STO, 8'd1, 16'h0007);
                    8'd2: instr = mk_imm(OP_STO, 8'd2, 16'h0000);
                    8'd3: instr = mk_imm(OP_STO, 8'd3, 16'h0001);
                    8'd4: instr = mk_instr(OP_ADD, 8'd2, 8'd2, 8'd3);
                    8'd5: instr = mk_instr(OP_LED, 8'd0, 8'd2, 8'd0);
                    8'd6: instr = mk_instr(OP_BLE, 8'd4, 8'd2, 8'd1);
                    8'd7: instr = mk_instr(OP_SMUL, 8'd4, 8'd2, 8'd1);
                    8'd8: instr = mk_instr(OP_LED, 8'd0, 8'd4, 8'd0);
                    8'd9: instr = mk_instr(OP_JMP, 8'd9, 8'd0, 8'd0);
                    default: ;
                endcase
            end else begin
                case (addr)
                    8'd0:   instr = mk_imm(OP_STO, 8'd1, 16'hFFFF);
                    8'd1:   instr = mk_imm(OP_STO, 8'd2, 16'h0001);
                    8'd2:   instr = mk_instr(OP_ADD, 8'd3, 8'd1, 8'd2);
                    8'd3:   instr = mk_instr(OP_SUB, 8'd4, 8'd3, 8'd2);
                    8'd4:   instr = mk_imm(OP_STO, 8'd5, 16'h00FF);
                    8'd5:   instr = mk_imm(OP_STO, 8'd6, 16'h0002);
                    8'd6:   instr = mk_instr(OP_SMUL, 8'd7, 8'd5, 8'd6);
                    8'd7:   instr = mk_instr(4'hF, 8'd1, 8'd2, 8'd3);
                    8'd8:   instr = mk_instr(OP_ADD, 8'd1, 8'd1, 8'd1);
                    8'd9:   instr = mk_instr(OP_LED, 8'd0, 8'd4, 8'd0);
                    8'd10:  instr = mk_instr(OP_BLE, 8'd13, 8'd2, 8'd2);
                    8'd11:  instr = mk_imm(OP_STO, 8'd8, 16'hDEAD);
                    8'd12:  instr = mk_imm(OP_STO, 8'd8, 16'hDEAD);
                    8'd13:  instr = mk_instr(OP_BLE, 8'd15, 8'd9, 8'd0);
                    8'd14:  instr = mk_instr(OP_JMP, 8'd14, 8'd0, 8'd0);
                    8'd15:  instr = mk_instr(OP_JMP, 8'd254, 8'd0, 8'd0);
                    8'd255: instr = mk_imm(OP_STO, 8'd9, 16'h1234);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/mini_alu.sv
// mini_alu: single-cycle 16-register micro-sequencer driving an LED port.
// SMUL is only built when MINI_ALU_SMUL_EN is defined; otherwise it is a NOP.
module mini_alu
    import mini_alu_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int REG_COUNT = 16,
    parameter int ROM_DEPTH = 256,
    parameter int PROG      = 0
) (
    input  logic       Clock,
    input  logic       Reset,
    output logic [7:0] oLed,
    mini_alu_if.slave  dbg
);

    localparam int RA_W = $clog2(REG_COUNT);

    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_nxt;
    logic [DATA_W-1:0] regs [REG_COUNT];
    logic [7:0]        led_nxt;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [IMM_W-1:0]  imm;
    instr_t            ins;

    mini_alu_rom #(
        .ROM_DEPTH (ROM_DEPTH),
        .PROG      (PROG)
    ) u_rom (
        .addr  (pc),
        .instr (ins)
    );

    assign a   = regs[ins.src1[RA_W-1:0]];
    assign b   = regs[ins.src0[RA_W-1:0]];
    assign imm = {ins.src1, ins.src0};

    assign dbg.pc    = pc;
    assign dbg.rdata = regs[dbg.sel[RA_W-1:0]];

    // decode/execute: sources are read before the edge, so dest==src sees old data
    always_comb begin
        pc_nxt  = pc + 8'd1;
        led_nxt = oLed;
        wr_en   = 1'b0;
        wr_data = '0;
        unique case (ins.op)
            OP_LED: led_nxt = a[7:0];
            OP_BLE: begin
                if (a <= b) pc_nxt = ins.dest;
            end
            OP_STO: begin
                wr_en   = 1'b1;
                wr_data = DATA_W'(imm);
            end
            OP_ADD: begin
                wr_en   = 1'b1;
                wr_data = a + b;
            end
            OP_JMP: pc_nxt = ins.dest;
            OP_SUB: begin
                wr_en   = 1'b1;
                wr_data = a - b;
            end
            OP_SMUL: begin
`ifdef MINI_ALU_SMUL_EN
                wr_en   = 1'b1;
                wr_data = DATA_W'(smul8(a[7:0], b[7:0]));
`endif
            end
            default: ;
        endcase
    end

    // architectural state: PC, LED latch and register file
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc   <= '0;
            oLed <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            pc   <= pc_nxt;
            oLed <= led_nxt;
            if (wr_en) begin
                regs[ins.dest[RA_W-1:0]] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_mini_alu.sv
// tb_mini_alu: instruction-level reference model checked every edge,
// plus directed timing checks on the LED sequence and boundary programs.
module tb_mini_alu;

    logic       clk;
    logic       rst_a;
    logic       rst_b;
    logic [7:0] led_a;
    logic [7:0] led_b;

    mini_alu_if #(.DATA_W(16)) bus_a ();
    mini_alu_if #(.DATA_W(16)) bus_b ();

    mini_alu #(
        .DATA_W    (16),
        .REG_COUNT (16),
        .ROM_DEPTH (256),
        .PROG      (0)
    ) u_dut (
        .Clock (clk),
        .Reset (rst_a),
        .oLed  (led_a),
        .dbg   (bus_a.slave)
    );

    mini_alu #(
        .DATA_W    (16),
        .REG_COUNT (16),
        .ROM_DEPTH (256),
        .PROG      (1)
    ) u_alt (
        .Clock (clk),
        .Reset (rst_b),
        .oLed  (led_b),
        .dbg   (bus_b.slave)
    );

`ifdef MINI_ALU_SMUL_EN
    localparam bit SMUL_ON = 1'b1;
`else
    localparam bit SMUL_ON = 1'b0;
`endif

    int n_tests;
    int n_fail;

    int m_op [256];
    int m_d  [256];
    int m_s1 [256];
    int m_s0 [256];
    int m_r  [16];
    int m_pc;
    int m_led;

    initial begin
        clk = 1'b0;
        forever #25 clk = ~clk;
    end

    task automatic setp(input int ad, input int op, input int d,
                        input int s1, input int s0);
        m_op[ad] = op;
        m_d[ad]  = d;
        m_s1[ad] = s1;
        m_s0[ad] = s0;
    endtask

    task automatic seti(input int ad, input int op, input int d, input int imm);
        setp(ad, op, d, imm / 256, imm % 256);
    endtask

    task automatic m_reset();
        m_pc  = 0;
        m_led = 0;
        for (int i = 0; i < 16; i++) m_r[i] = 0;
    endtask

    task automatic load_prog(input int p);
        for (int i = 0; i < 256; i++) setp(i, 0, 0, 0, 0);
        if (p == 0) begin
            seti(1, 3, 1, 7);
            seti(2, 3, 2, 0);
            seti(3, 3, 3, 1);
            setp(4, 4, 2, 2, 3);
            setp(5, 1, 0, 2, 0);
            setp(6, 2, 4, 2, 1);
            setp(7, 7, 4, 2, 1);
            setp(8, 1, 0, 4, 0);
            setp(9, 5, 9, 0, 0);
        end else begin
            seti(0, 3, 1, 'hFFFF);
            seti(1, 3, 2, 1);
            setp(2, 4, 3, 1, 2);
            setp(3, 6, 4, 3, 2);
            seti(4, 3, 5, 'h00FF);
            seti(5, 3, 6, 2);
            setp(6, 7, 7, 5, 6);
            setp(7, 15, 1, 2, 3);
            setp(8, 4, 1, 1, 1);
            setp(9, 1, 0, 4, 0);
            setp(10, 2, 13, 2, 2);
            seti(11, 3, 8, 'hDEAD);
            seti(12, 3, 8, 'hDEAD);
            setp(13, 2, 15, 9, 0);
            setp(14, 5, 14, 0, 0);
            setp(15, 5, 254, 0, 0);
            seti(255, 3, 9, 'h1234);
        end
        m_reset();
    endtask

    // one instruction of the ISA, plain integer arithmetic
    task automatic m_step();
        int op, d, x, y, nxt, sx, sy, p;
        op  = m_op[m_pc];
        d   = m_d[m_pc] % 16;
        x   = m_r[m_s1[m_pc] % 16];
        y   = m_r[m_s0[m_pc] % 16];
        nxt = (m_pc + 1) % 256;
        case (op)
            1: m_led = x % 256;
            2: if (x <= y) nxt = m_d[m_pc];
            3: m_r[d] = m_s1[m_pc] * 256 + m_s0[m_pc];
            4: m_r[d] = (x + y) % 65536;
            5: nxt = m_d[m_pc];
            6: m_r[d] = (x - y + 65536) % 65536;
            7: begin
                if (SMUL_ON) begin
                    sx = x % 256;
                    sy = y % 256;
                    if (sx >= 128) sx = sx - 256;
                    if (sy >= 128) sy = sy - 256;
                    p = sx * sy;
                    if (p < 0) p = p + 65536;
                    m_r[d] = p;
                end
            end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic read_reg(input int which, input int idx, output logic [15:0] v);
        if (which == 0) bus_a.sel = 4'(idx);
        else bus_b.sel = 4'(idx);
        #1;
        v = (which == 0) ? bus_a.rdata : bus_b.rdata;
    endtask

    // advance one edge on the model and compare pc, LED and a random register
    task automatic step_check(input int which, input string tag);
        logic        r;
        logic [7:0]  got_pc, got_led, exp_pc, exp_led;
        logic [15:0] got_r, exp_r;
        int          s;
        r = (which == 0) ? rst_a : rst_b;
        @(posedge clk);
        if (r) m_reset();
        else m_step();
        #1;
        s = $urandom_range(0, 15);
        bus_a.sel = 4'(s);
        bus_b.sel = 4'(s);
        #1;
        got_pc  = (which == 0) ? bus_a.pc : bus_b.pc;
        got_led = (which == 0) ? led_a : led_b;
        got_r   = (which == 0) ? bus_a.rdata : bus_b.rdata;
        exp_pc  = 8'(m_pc);
        exp_led = 8'(m_led);
        exp_r   = 16'(m_r[s]);
        n_tests++;
        if (got_pc !== exp_pc) begin
            n_fail++;
            $display("FAIL %s pc: got %h want %h", tag, got_pc, exp_pc);
        end
        n_tests++;
        if (got_led !== exp_led) begin
            n_fail++;
            $display("FAIL %s led: got %h want %h", tag, got_led, exp_led);
        end
        n_tests++;
        if (got_r !== exp_r) begin
            n_fail++;
            $display("FAIL %s R%0d: got %h want %h", tag, s, got_r, exp_r);
        end
    endtask

    // default program from reset release: LED 1..8 every 3 edges, then exit value
    task automatic run_sequence(input string tag);
        logic [7:0] fin;
        fin = SMUL_ON ? 8'h38 : 8'h00;
        for (int e = 1; e <= 40; e++) begin
            step_check(0, tag);
            for (int k = 1; k <= 8; k++) begin
                if (e == 6 + 3 * (k - 1)) begin
                    n_tests++;
                    if (led_a !== 8'(k)) begin
                        n_fail++;
                        $display("FAIL %s led_step%0d: got %h want %h", tag, k, led_a, 8'(k));
                    end
                end
            end
            if (e == 5 || e == 30 || e == 40) begin
                n_tests++;
                if (led_a !== ((e == 5) ? 8'h00 : fin)) begin
                    n_fail++;
                    $display("FAIL %s led_edge%0d: got %h want %h", tag, e, led_a,
                             (e == 5) ? 8'h00 : fin);
                end
            end
        end
        n_tests++;
        if (bus_a.pc !== 8'd9) begin
            n_fail++;
            $display("FAIL %s hold_pc: got %h want 09", tag, bus_a.pc);
        end
    endtask

    task automatic test_reset();
        logic [15:0] v;
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int i = 0; i < 5; i++) step_check(0, "reset");
        n_tests++;
        if (led_a !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_led: got %h want 00", led_a);
        end
        n_tests++;
        if (bus_a.pc !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_pc: got %h want 00", bus_a.pc);
        end
        for (int i = 1; i <= 4; i++) begin
            read_reg(0, i, v);
            n_tests++;
            if (v !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_R%0d: got %h want 0000", i, v);
            end
        end
        n_tests++;
        if (led_b !== 8'h00 || bus_b.pc !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_alt: got led %h pc %h want 00 00", led_b, bus_b.pc);
        end
    endtask

    task automatic test_led_sequence();
        rst_a = 1'b0;
        run_sequence("seq");
    endtask

    task automatic test_reset_mid();
        bit found;
        int nx;
        rst_a = 1'b1;
        step_check(0, "mid_pre");
        rst_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step_check(0, "mid_run");
            if (m_led == 4) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL mid_timeout: got no led 4 want led 4 within 40 edges");
        end
        n_tests++;
        if (led_a !== 8'd4) begin
            n_fail++;
            $display("FAIL mid_led4: got %h want 04", led_a);
        end
        rst_a = 1'b1;
        step_check(0, "mid_rst");
        n_tests++;
        if (led_a !== 8'h00 || bus_a.pc !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_abort: got led %h pc %h want 00 00", led_a, bus_a.pc);
        end
        nx = $urandom_range(0, 3);
        for (int i = 0; i < nx; i++) step_check(0, "mid_hold");
        rst_a = 1'b0;
        run_sequence("mid_seq");
    endtask

    task automatic test_random_reset();
        int n;
        for (int t = 0; t < 3; t++) begin
            rst_a = 1'b1;
            step_check(0, "rnd_rst");
            rst_a = 1'b0;
            n = $urandom_range(1, 28);
            for (int i = 0; i < n; i++) step_check(0, "rnd_run");
            rst_a = 1'b1;
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) step_check(0, "rnd_hold");
            rst_a = 1'b0;
            run_sequence("rnd_seq");
        end
    endtask

    task automatic test_alt_rom();
        logic [15:0] v;
        logic [15:0] want7;
        want7 = SMUL_ON ? 16'hFFFE : 16'h0000;
        rst_a = 1'b1;
        load_prog(1);
        rst_b = 1'b1;
        step_check(1, "alt_rst");
        rst_b = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            step_check(1, "alt");
            if (e == 8) begin
                n_tests++;
                if (bus_b.pc !== 8'd8 || led_b !== 8'h00) begin
                    n_fail++;
                    $display("FAIL undef_op: got pc %h led %h want 08 00", bus_b.pc, led_b);
                end
                for (int i = 0; i < 16; i++) begin
                    read_reg(1, i, v);
                    n_tests++;
                    if (v !== 16'(m_r[i])) begin
                        n_fail++;
                        $display("FAIL undef_R%0d: got %h want %h", i, v, 16'(m_r[i]));
                    end
                end
            end
            if (e == 15) begin
                n_tests++;
                if (bus_b.pc !== 8'd0) begin
                    n_fail++;
                    $display("FAIL pc_wrap: got %h want 00", bus_b.pc);
                end
            end
        end
        n_tests++;
        if (bus_b.pc !== 8'd14 || led_b !== 8'hFF) begin
            n_fail++;
            $display("FAIL alt_end: got pc %h led %h want 0e ff", bus_b.pc, led_b);
        end
        read_reg(1, 3, v);
        n_tests++;
        if (v !== 16'h0000) begin
            n_fail++;
            $display("FAIL add_wrap: got %h want 0000", v);
        end
        read_reg(1, 4, v);
        n_tests++;
        if (v !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sub_wrap: got %h want ffff", v);
        end
        read_reg(1, 7, v);
        n_tests++;
        if (v !== want7) begin
            n_fail++;
            $display("FAIL smul_neg: got %h want %h", v, want7);
        end
        read_reg(1, 1, v);
        n_tests++;
        if (v !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL same_reg_add: got %h want fffe", v);
        end
        read_reg(1, 8, v);
        n_tests++;
        if (v !== 16'h0000) begin
            n_fail++;
            $display("FAIL ble_taken: got R8 %h want 0000", v);
        end
        read_reg(1, 9, v);
        n_tests++;
        if (v !== 16'h1234) begin
            n_fail++;
            $display("FAIL sto_255: got R9 %h want 1234", v);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_a     = 1'b1;
        rst_b     = 1'b1;
        bus_a.sel = 4'd0;
        bus_b.sel = 4'd0;
        load_prog(0);
        test_reset();
        test_led_sequence();
        test_reset_mid();
        test_random_reset();
        test_alt_rom();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
